// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 keystream generation, XOR-decrypt of ROM message into RAM, printable-text key check
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW = 5,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [MSG_AW-1:0] decrypt_address,
  output logic [7:0]        decrypt_data,
  output logic              decrypt_wren
);
  localparam logic [MSG_AW-1:0] LAST = MSG_AW'(MSG_LEN - 1);
  typedef enum logic [3:0] {
    IDLE, INC_I, WAIT_SI, READ_SI, WAIT_SJ, READ_SJ, WRITE_SI,
    WRITE_SJ, ADDR_F, WAIT_F, READ_F, WRITE_DEC, DONE
  } state_t;
  state_t state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, p_q, p_d;
  logic [7:0] s_address_q, s_address_d, s_data_q, s_data_d, decrypt_data_q, decrypt_data_d;
  logic [MSG_AW-1:0] k_q, k_d, rom_address_q, rom_address_d, decrypt_address_q, decrypt_address_d;
  logic busy_q, busy_d, done_q, done_d, key_valid_q, key_valid_d;
  logic s_wren_q, s_wren_d, decrypt_wren_q, decrypt_wren_d;
  logic printable;
  assign printable = p_q == 8'h20 || (p_q >= 8'h61 && p_q <= 8'h7a);
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    si_d = si_q;
    sj_d = sj_q;
    p_d = p_q;
    s_address_d = s_address_q;
    s_data_d = s_data_q;
    s_wren_d = 1'b0;
    rom_address_d = rom_address_q;
    decrypt_address_d = decrypt_address_q;
    decrypt_data_d = decrypt_data_q;
    decrypt_wren_d = 1'b0;
    key_valid_d = key_valid_q;
    done_d = state_q == DONE;
    busy_d = state_q != IDLE || start;
    case (state_q)
      IDLE: if (start) begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        key_valid_d = 1'b0;
        state_d = INC_I;
      end
      INC_I: begin
        i_d = i_q + 8'd1;
        s_address_d = i_q + 8'd1;
        state_d = WAIT_SI;
      end
      WAIT_SI: state_d = READ_SI;
      READ_SI: begin
        si_d = s_q;
        j_d = j_q + s_q;
        s_address_d = j_q + s_q;
        state_d = WAIT_SJ;
      end
      WAIT_SJ: state_d = READ_SJ;
      READ_SJ: begin
        sj_d = s_q;
        state_d = WRITE_SI;
      end
      WRITE_SI: begin
        s_address_d = i_q;
        s_data_d = sj_q;
        s_wren_d = 1'b1;
        state_d = WRITE_SJ;
      end
      WRITE_SJ: begin
        s_address_d = j_q;
        s_data_d = si_q;
        s_wren_d = 1'b1;
        state_d = ADDR_F;
      end
      ADDR_F: begin
        s_address_d = si_q + sj_q;
        rom_address_d = k_q;
        state_d = WAIT_F;
      end
      WAIT_F: state_d = READ_F;
      READ_F: begin
        p_d = s_q ^ rom_q;
        state_d = WRITE_DEC;
      end
      WRITE_DEC: begin
        decrypt_address_d = k_q;
        decrypt_data_d = p_q;
        decrypt_wren_d = 1'b1;
        if (CHECK_EN && !printable) begin
          key_valid_d = 1'b0;
          state_d = DONE;
        end else if (k_q == LAST) begin
          key_valid_d = 1'b1;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
          state_d = INC_I;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      si_q <= '0;
      sj_q <= '0;
      p_q <= '0;
      s_address_q <= '0;
      s_data_q <= '0;
      s_wren_q <= 1'b0;
      rom_address_q <= '0;
      decrypt_address_q <= '0;
      decrypt_data_q <= '0;
      decrypt_wren_q <= 1'b0;
      key_valid_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      si_q <= si_d;
      sj_q <= sj_d;
      p_q <= p_d;
      s_address_q <= s_address_d;
      s_data_q <= s_data_d;
      s_wren_q <= s_wren_d;
      rom_address_q <= rom_address_d;
      decrypt_address_q <= decrypt_address_d;
      decrypt_data_q <= decrypt_data_d;
      decrypt_wren_q <= decrypt_wren_d;
      key_valid_q <= key_valid_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign key_valid = key_valid_q;
  assign s_address = s_address_q;
  assign s_data = s_data_q;
  assign s_wren = s_wren_q;
  assign rom_address = rom_address_q;
  assign decrypt_address = decrypt_address_q;
  assign decrypt_data = decrypt_data_q;
  assign decrypt_wren = decrypt_wren_q;
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb_rc4_prga_decrypt: directed bench with software RC4 model and write scoreboard
module tb_rc4_prga_decrypt;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, sel = 1'b0, load = 1'b0;
  always #5 clock = ~clock;
  logic busy_a, done_a, kv_a, sw_a, dw_a, busy_b, done_b, kv_b, sw_b, dw_b;
  logic [7:0] sa_a, sd_a, dd_a, sa_b, sd_b, dd_b;
  logic [4:0] ra_a, da_a, ra_b, da_b;
  logic [7:0] s_q, rom_q;
  rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(5), .CHECK_EN(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start && !sel), .busy(busy_a), .done(done_a),
    .key_valid(kv_a), .s_address(sa_a), .s_data(sd_a), .s_wren(sw_a), .s_q(s_q),
    .rom_address(ra_a), .rom_q(rom_q), .decrypt_address(da_a), .decrypt_data(dd_a),
    .decrypt_wren(dw_a));
  rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(5), .CHECK_EN(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start && sel), .busy(busy_b), .done(done_b),
    .key_valid(kv_b), .s_address(sa_b), .s_data(sd_b), .s_wren(sw_b), .s_q(s_q),
    .rom_address(ra_b), .rom_q(rom_q), .decrypt_address(da_b), .decrypt_data(dd_b),
    .decrypt_wren(dw_b));
  logic busy, done, key_valid, s_wren, decrypt_wren;
  logic [7:0] s_address, s_data, decrypt_data;
  logic [4:0] rom_address, decrypt_address;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign key_valid = sel ? kv_b : kv_a;
  assign s_address = sel ? sa_b : sa_a;
  assign s_data = sel ? sd_b : sd_a;
  assign s_wren = sel ? sw_b : sw_a;
  assign rom_address = sel ? ra_b : ra_a;
  assign decrypt_address = sel ? da_b : da_a;
  assign decrypt_data = sel ? dd_b : dd_a;
  assign decrypt_wren = sel ? dw_b : dw_a;
  logic [7:0] s_mem [256];
  logic [7:0] init_s [256];
  logic [7:0] exp_s [256];
  logic [7:0] rom [32];
  logic [7:0] dec [32];
  logic [7:0] exp_p [32];
  int wcnt [32];
  int exp_n, widx, checks = 0, errors = 0;
  bit exp_kv;
  string pt = "the quick brown fox jumps over a";
  always @(posedge clock) begin
    if (load) for (int n = 0; n < 256; n++) s_mem[n] <= init_s[n];
    else if (s_wren) s_mem[s_address] <= s_data;
    s_q <= s_mem[s_address];
    rom_q <= rom[rom_address];
    if (decrypt_wren) dec[decrypt_address] <= decrypt_data;
  end
  always @(negedge clock) begin
    if (load) begin
      widx = 0;
      for (int a = 0; a < 32; a++) wcnt[a] = 0;
    end else if (decrypt_wren) begin
      checks++;
      if (widx > 31 || decrypt_address !== 5'(widx) || decrypt_data !== exp_p[widx]) begin
        errors++;
        $display("FAIL dec_write #%0d: got addr %0d data %h, want addr %0d data %h",
                 widx, decrypt_address, decrypt_data, widx, widx > 31 ? 8'h00 : exp_p[widx]);
      end
      wcnt[decrypt_address]++;
      widx++;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic model(input bit ce);
    logic [7:0] s [256];
    logic [7:0] i, j, t, f, p;
    s = init_s;
    i = 0;
    j = 0;
    exp_n = 0;
    exp_kv = 1'b1;
    for (int k = 0; k < 32; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      f = s[i] + s[j];
      p = rom[k] ^ s[f];
      exp_p[k] = p;
      exp_n = k + 1;
      if (ce && !(p == 8'h20 || (p >= 8'h61 && p <= 8'h7a))) begin
        exp_kv = 1'b0;
        break;
      end
    end
    exp_s = s;
  endtask
  task automatic load_s(input bit rev);
    for (int n = 0; n < 256; n++) init_s[n] = rev ? 8'(255 - n) : 8'(n);
    @(posedge clock);
    #1 load = 1'b1;
    @(posedge clock);
    #1 load = 1'b0;
  endtask
  task automatic check_zero(input string name);
    chk(name, {busy, done, key_valid, s_wren, decrypt_wren, s_address, s_data, rom_address,
               decrypt_address, decrypt_data}, 64'd0);
  endtask
  task automatic run(input bit b, input int pulse_at, input int rst_at);
    int n, bad, quiet;
    sel = b;
    model(!b);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    n = 0;
    while (!done && n < 1000) begin
      @(posedge clock);
      n++;
      #1 start = n == pulse_at;
      if (n == rst_at) begin
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        check_zero("outs_after_midrun_reset");
        quiet = 0;
        repeat (40) begin
          @(posedge clock);
          #1 quiet += int'(s_wren) + int'(decrypt_wren) + int'(busy) + int'(done);
        end
        chk("quiet_after_reset", quiet, 0);
        bad = 0;
        for (int a = 0; a < 32; a++) bad += int'(wcnt[a] != (a < 10 ? 1 : 0));
        chk("writes_before_reset", bad, 0);
        return;
      end
    end
    chk("done_latency", n, 11 * exp_n + 1);
    chk("key_valid", key_valid, exp_kv);
    chk("busy_in_done_cycle", busy, 1'b1);
    @(posedge clock);
    #1 chk("idle_after_done", {busy, done}, 2'b00);
    chk("key_valid_held", key_valid, exp_kv);
    bad = 0;
    for (int a = 0; a < 32; a++) bad += int'(wcnt[a] != (a < exp_n ? 1 : 0));
    chk("ram_write_counts", bad, 0);
    bad = 0;
    for (int a = 0; a < 256; a++) bad += int'(s_mem[a] !== exp_s[a]);
    chk("final_s", bad, 0);
  endtask
  initial begin
    for (int k = 0; k < 32; k++) rom[k] = 8'h00;
    repeat (3) @(posedge clock);
    #1 check_zero("reset_outs");
    reset_n = 1'b1;
    for (int n = 0; n < 256; n++) init_s[n] = 8'(n);
    model(1'b0);
    chk("model_ks0", exp_p[0], 8'd2);
    chk("model_ks1", exp_p[1], 8'd5);
    chk("model_ks2", exp_p[2], 8'd7);
    for (int k = 0; k < 32; k++) rom[k] = pt[k] ^ exp_p[k];
    load_s(1'b0);
    run(1'b0, -1, -1);
    chk("t1_kv", key_valid, 1'b1);
    chk("t1_dec0", dec[0], 8'h74);
    chk("t1_dec31", dec[31], 8'h61);
    chk("t1_s1_same_addr", s_mem[1], 8'd1);
    load_s(1'b1);
    run(1'b0, -1, -1);
    chk("t2_kv", key_valid, 1'b0);
    chk("t2_dec2", dec[2], 8'h99);
    chk("t2_last_written", wcnt[2], 1);
    chk("t2_not_written", wcnt[3], 0);
    load_s(1'b0);
    run(1'b0, -1, 11 * 10 + 3);
    load_s(1'b0);
    run(1'b0, 11 * 5 + 2, -1);
    chk("t5_kv", key_valid, 1'b1);
    chk("t5_dec31", dec[31], 8'h61);
    for (int k = 0; k < 32; k++) rom[k] = 8'($urandom_range(0, 255));
    load_s(1'b0);
    run(1'b1, -1, -1);
    chk("t6_kv", key_valid, 1'b1);
    chk("t6_all_written", wcnt[31], 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
